// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the control unit, instruction register, PC
// and accumulator of the 8-bit accumulator CPU.
//   CPU_OPW / CPU_ADDRW : default opcode and operand-address field widths
//   OP_*                : opcode encodings (Opcode[7:5])
//   state_t             : control sequencer state encoding
package cpu_pkg;

    localparam int CPU_OPW   = 3;
    localparam int CPU_ADDRW = 5;

    localparam logic [CPU_OPW-1:0] OP_HLT = 3'b000;
    localparam logic [CPU_OPW-1:0] OP_LDA = 3'b001;
    localparam logic [CPU_OPW-1:0] OP_STA = 3'b010;
    localparam logic [CPU_OPW-1:0] OP_ADD = 3'b011;
    localparam logic [CPU_OPW-1:0] OP_SUB = 3'b100;
    localparam logic [CPU_OPW-1:0] OP_JMP = 3'b101;
    localparam logic [CPU_OPW-1:0] OP_JZ  = 3'b110;
    localparam logic [CPU_OPW-1:0] OP_NOP = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_F_ADDR  = 3'd1,
        ST_F_READ  = 3'd2,
        ST_DECODE  = 3'd3,
        ST_M_READ  = 3'd4,
        ST_M_WRITE = 3'd5,
        ST_HALT    = 3'd6,
        ST_FAULT   = 3'd7
    } state_t;

    // States in which a memory access is outstanding and mem_ready matters.
    function automatic logic is_mem_wait(input state_t s);
        return (s == ST_F_READ) || (s == ST_M_READ) || (s == ST_M_WRITE);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts cycles a memory access has waited for mem_ready and
// flags when the access has used up its LIMIT-cycle budget.
//   clk     : system clock, rising edge
//   reset   : asynchronous, active-low
//   clear   : hold the count at zero (no access outstanding)
//   en      : access outstanding and mem_ready low this cycle
//   expired : this is the LIMIT-th waiting cycle; the access faults
module mem_wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    // The count holds the number of cycles already waited, so the access
    // runs out when this would be wait cycle number LIMIT. A mem_ready on
    // that cycle deasserts en and lets the access complete.
    assign expired = en && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle fetch/decode/execute sequencer for the 8-bit
// accumulator CPU. Outputs are decoded combinationally from the state, the
// opcode field, zero and mem_ready.
//   clk, reset (async, active-low), start
//   Opcode      : instruction register contents {op[7:5], addr[4:0]}
//   zero        : accumulator == 0
//   mem_ready   : memory finished the current access this cycle
//   load_mar / sel_operand : MAR load, address source (0 = PC, 1 = operand)
//   mem_rd / mem_wr        : memory read / write request
//   LoadIR, inc_pc, load_pc: IR capture, PC step, PC load from operand
//   load_acc / acc_src / alu_sub : accumulator load, source, ALU op
//   halted, fault          : status for HALT and FAULT states
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int OPW        = cpu_pkg::CPU_OPW,
    parameter int ADDRW      = cpu_pkg::CPU_ADDRW,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [OPW+ADDRW-1:0] Opcode,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 load_mar,
    output logic                 sel_operand,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic                 LoadIR,
    output logic                 inc_pc,
    output logic                 load_pc,
    output logic                 load_acc,
    output logic                 acc_src,
    output logic                 alu_sub,
    output logic                 halted,
    output logic                 fault
);

    state_t         state;
    logic [OPW-1:0] op;
    logic           in_wait;
    logic           wait_expired;

    assign op      = Opcode[OPW+ADDRW-1 -: OPW];
    assign in_wait = is_mem_wait(state);

    // The operand address goes straight to the MAR mux, not through here.
    logic unused_addr;
    assign unused_addr = ^Opcode[ADDRW-1:0];

    // Every wait state is entered from a non-wait state, so holding the
    // counter clear outside them clears it on each entry.
    mem_wait_timer #(
        .LIMIT   (WAIT_LIMIT)
    ) u_wait (
        .clk     (clk),
        .reset   (reset),
        .clear   (!in_wait),
        .en      (in_wait && !mem_ready),
        .expired (wait_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (start) state <= ST_F_ADDR;
                ST_F_ADDR: state <= ST_F_READ;
                ST_F_READ: begin
                    if (mem_ready)         state <= ST_DECODE;
                    else if (wait_expired) state <= ST_FAULT;
                end
                ST_DECODE: begin
                    case (op)
                        OP_HLT:                 state <= ST_HALT;
                        OP_LDA, OP_ADD, OP_SUB: state <= ST_M_READ;
                        OP_STA:                 state <= ST_M_WRITE;
                        default:                state <= ST_F_ADDR;
                    endcase
                end
                ST_M_READ, ST_M_WRITE: begin
                    if (mem_ready)         state <= ST_F_ADDR;
                    else if (wait_expired) state <= ST_FAULT;
                end
                ST_HALT:  state <= ST_HALT;
                ST_FAULT: state <= ST_FAULT;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        load_mar    = 1'b0;
        sel_operand = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        LoadIR      = 1'b0;
        inc_pc      = 1'b0;
        load_pc     = 1'b0;
        load_acc    = 1'b0;
        acc_src     = 1'b0;
        alu_sub     = 1'b0;
        halted      = 1'b0;
        fault       = 1'b0;
        case (state)
            ST_F_ADDR: load_mar = 1'b1;
            ST_F_READ: begin
                mem_rd = 1'b1;
                LoadIR = mem_ready;
                inc_pc = mem_ready;
            end
            ST_DECODE: begin
                case (op)
                    OP_JMP: load_pc = 1'b1;
                    OP_JZ:  load_pc = zero;
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        load_mar    = 1'b1;
                        sel_operand = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_M_READ: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    load_acc = 1'b1;
                    acc_src  = (op == OP_ADD) || (op == OP_SUB);
                    alu_sub  = (op == OP_SUB);
                end
            end
            ST_M_WRITE: mem_wr = 1'b1;
            ST_HALT:    halted = 1'b1;
            ST_FAULT:   fault  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Multi-cycle sequencer for the 8-bit accumulator CPU.
- Drives the fetch/decode/execute cycle:
  - addresses memory through the MAR;
  - strobes the instruction register (LoadIR);
  - steps or loads the PC;
  - commands accumulator/ALU loads and memory reads and writes.
- Reads the opcode back from the instruction register and the zero flag from the ALU.
- Handshakes with variable-latency memory via mem_ready and flags a fault on a stalled access.

Parameters:
- OPW, 3, opcode width (Opcode[7:5]).
- ADDRW, 5, operand address width (Opcode[4:0]).
- WAIT_LIMIT, 15, maximum cycles a memory access may wait for mem_ready before faulting.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low (0 = reset asserted).
- start  input  1  leaves IDLE and begins fetching from the current PC.
- Opcode  input  8  instruction held in the instruction register.
- zero  input  1  accumulator == 0.
- mem_ready  input  1  memory completed the current read/write this cycle.
- load_mar  output  1  MAR captures the address selected by sel_operand.
- sel_operand  output  1  0 = PC drives the MAR, 1 = Opcode[4:0] drives the MAR.
- mem_rd  output  1  memory read request.
- mem_wr  output  1  memory write request (data = accumulator).
- LoadIR  output  1  instruction register captures memory data.
- inc_pc  output  1  PC <= PC+1 (wraps 31->0).
- load_pc  output  1  PC <= Opcode[4:0].
- load_acc  output  1  accumulator captures the source selected by acc_src.
- acc_src  output  1  0 = memory data, 1 = ALU result.
- alu_sub  output  1  0 = add, 1 = subtract.
- halted  output  1  high in HALT.
- fault  output  1  high in FAULT.

Behaviour:
- State register:
  - Updates on posedge clk.
  - reset low forces IDLE immediately (asynchronous), including mid-access; a pending memory request is abandoned.
  - In IDLE all outputs are 0.
- All outputs are combinational from state, Opcode[7:5], zero and mem_ready.
- Any output not listed as asserted in a state is 0.
- Opcodes (Opcode[7:5]): 000 HLT, 001 LDA, 010 STA, 011 ADD, 100 SUB, 101 JMP, 110 JZ, 111 NOP.
- IDLE:
  - start=1 -> F_ADDR.
  - Otherwise stay.
- F_ADDR:
  - load_mar=1, sel_operand=0.
  - -> F_READ.
- F_READ:
  - mem_rd=1.
  - If mem_ready: LoadIR=1, inc_pc=1, -> DECODE.
  - Otherwise wait.
- DECODE (uses the newly loaded Opcode):
  - HLT: -> HALT.
  - NOP: -> F_ADDR.
  - JMP: load_pc=1, -> F_ADDR.
  - JZ: load_pc=zero, -> F_ADDR.
  - LDA/ADD/SUB: load_mar=1, sel_operand=1, -> M_READ.
  - STA: load_mar=1, sel_operand=1, -> M_WRITE.
- M_READ:
  - mem_rd=1.
  - On mem_ready:
    - LDA: load_acc=1, acc_src=0.
    - ADD: load_acc=1, acc_src=1, alu_sub=0.
    - SUB: load_acc=1, acc_src=1, alu_sub=1.
  - Then -> F_ADDR.
- M_WRITE:
  - mem_wr=1.
  - On mem_ready -> F_ADDR.
- HALT:
  - halted=1.
  - Stays until reset; start is ignored.
- FAULT:
  - fault=1.
  - Stays until reset.
- Wait counter:
  - Cleared on entry to F_READ, M_READ and M_WRITE.
  - Increments each cycle mem_ready=0 in those states.
  - When it reaches WAIT_LIMIT with mem_ready still 0 -> FAULT next edge.
  - mem_ready=1 on the same cycle as the limit wins (the access completes).
- mem_ready outside F_READ/M_READ/M_WRITE is ignored.
- mem_rd and mem_wr are never both 1.
- Minimum instruction latency with zero-wait memory:
  - NOP/JMP/JZ/HLT: 3 cycles.
  - LDA/ADD/SUB/STA: 4 cycles.
- The counter width is the minimum that holds WAIT_LIMIT.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants (OP_HLT..OP_NOP);
  - state encoding constants;
  - OPW/ADDRW defaults.
- The instruction register, PC and accumulator also use these constants.
- One natural sub-module: mem_wait_timer, holding the wait counter and timeout compare (clear, count enable, expired).
- Everything else stays in cpu_control_unit.

Test Plan:
- Reset and start:
  - Stimulus: reset=0 for 2 cycles, release, hold start=0 for 5 cycles.
  - Response: state stays IDLE and all outputs are 0.
  - Stimulus: start=1.
  - Response: load_mar=1 with sel_operand=0 on the next cycle.
- LDA, zero-wait:
  - Stimulus: mem_ready tied 1, Opcode=8'b001_00101.
  - Response, in order: F_ADDR (load_mar); F_READ (LoadIR, inc_pc); DECODE (load_mar, sel_operand=1); M_READ (load_acc, acc_src=0). Back in F_ADDR on cycle 5.
- SUB with 3 wait cycles:
  - Stimulus: Opcode=8'b100_00011; mem_ready low for 3 cycles in M_READ, then high.
  - Response: mem_rd held 4 cycles; on the final cycle load_acc=1, acc_src=1, alu_sub=1.
- JZ both ways:
  - zero=1 with Opcode=8'b110_01010: load_pc=1 in DECODE.
  - zero=0: load_pc=0, inc_pc only during fetch.
- Timeout and abort:
  - Stimulus: STA with mem_ready held 0.
  - Response: mem_wr held for WAIT_LIMIT cycles, then FAULT with fault=1 and mem_wr=0.
  - Stimulus: assert reset.
  - Response: immediately IDLE, all outputs 0.
- HLT:
  - Stimulus: Opcode=8'b000_00000.
  - Response: halted=1 from the cycle after DECODE; start pulses have no effect; reset clears halted.
